// File: rtl/div_sp_pkg.sv
// Shared constants and types for the single-precision divider and its
// normalize/round/pack back end.
package div_sp_pkg;

  localparam int          BIAS         = 127;
  localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
  localparam logic [31:0] QNAN         = 32'h7FC0_0000;

  localparam logic [1:0] SPC_NORM = 2'b00;
  localparam logic [1:0] SPC_ZERO = 2'b01;
  localparam logic [1:0] SPC_INF  = 2'b10;
  localparam logic [1:0] SPC_NAN  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_ROUND,
    S_OUT
  } div_sp_state_t;

endpackage

// File: rtl/div_sp_rne_pack.sv
// Round-to-nearest-even and IEEE-754 single pack of a normalized mantissa.
// Overflow saturates to infinity; results below the normal range flush to zero.
module div_sp_rne_pack
  import div_sp_pkg::*;
#(
  parameter int EXP_W    = 10,
  parameter int EXP_BIAS = div_sp_pkg::BIAS
) (
  input  logic                     sign,
  input  logic signed [EXP_W:0]    exp,
  input  logic        [26:0]       mant,
  input  logic                     sticky,
  output logic        [31:0]       z
);

  localparam int BW = EXP_W + 2;
  localparam logic signed [BW-1:0] BIAS_X = BW'(EXP_BIAS);
  localparam logic signed [BW-1:0] BE_MAX = BW'(255);

  logic              lsb, grd, stk, up;
  logic [24:0]       r;
  logic [22:0]       frac;
  logic signed [BW-1:0] exp_x, inc, be;

  always_comb begin
    lsb   = mant[3];
    grd   = mant[2];
    stk   = mant[1] | mant[0] | sticky;
    up    = grd & (stk | lsb);
    r     = {1'b0, mant[26:3]} + {24'd0, up};
    // a carry out of the rounding add renormalizes by one place
    frac  = r[24] ? r[23:1] : r[22:0];
    exp_x = {exp[EXP_W], exp};
    inc   = {{(BW-1){1'b0}}, r[24]};
    be    = exp_x + inc + BIAS_X;
    z     = {sign, be[7:0], frac};
    if (be >= BE_MAX)
      z = {sign, EXP_ALL_ONES, 23'd0};
    else if (be[BW-1] || be == '0)
      z = {sign, 31'd0};
  end

endmodule

// File: rtl/div_sp_norm_round.sv
// Post-divide stage: normalizes the raw quotient one bit per cycle, rounds
// to nearest-even and holds the packed single until downstream takes it.
module div_sp_norm_round
  import div_sp_pkg::*;
#(
  parameter int          BIAS  = div_sp_pkg::BIAS,
  parameter int          EXP_W = 10,
  parameter logic [31:0] QNAN  = div_sp_pkg::QNAN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_sign,
  input  logic [EXP_W-1:0] i_exp,
  input  logic [26:0]      i_mant,
  input  logic             i_sticky,
  input  logic [1:0]       i_special,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_z
);

  typedef struct packed {
    logic             sign;
    logic [EXP_W:0]   exp;
    logic [26:0]      mant;
    logic             sticky;
  } op_t;

  div_sp_state_t state;
  op_t           op_q;
  logic [31:0]   pack_z;

  assign o_ready = (state == S_IDLE);

  div_sp_rne_pack #(.EXP_W(EXP_W), .EXP_BIAS(BIAS)) u_pack (
    .sign   (op_q.sign),
    .exp    ($signed(op_q.exp)),
    .mant   (op_q.mant),
    .sticky (op_q.sticky),
    .z      (pack_z)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= '0;
      o_z     <= '0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (i_valid) begin
          op_q <= '{sign: i_sign, exp: {i_exp[EXP_W-1], i_exp},
                    mant: i_mant, sticky: i_sticky};
          case (i_special)
            SPC_ZERO: begin
              o_z <= {i_sign, 31'd0};
              o_valid <= 1'b1;
              state <= S_OUT;
            end
            SPC_INF: begin
              o_z <= {i_sign, EXP_ALL_ONES, 23'd0};
              o_valid <= 1'b1;
              state <= S_OUT;
            end
            SPC_NAN: begin
              o_z <= QNAN;
              o_valid <= 1'b1;
              state <= S_OUT;
            end
            default: begin
              // a zero quotient would never normalize; short-circuit it
              if (i_mant == '0) begin
                o_z <= {i_sign, 31'd0};
                o_valid <= 1'b1;
                state <= S_OUT;
              end else begin
                state <= S_NORM;
              end
            end
          endcase
        end
        S_NORM: begin
          if (!op_q.mant[26]) begin
            op_q.mant <= op_q.mant << 1;
            op_q.exp  <= op_q.exp - 1'b1;
          end else begin
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          o_z     <= pack_z;
          o_valid <= 1'b1;
          state   <= S_OUT;
        end
        S_OUT: if (i_ready) begin
          o_valid <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sp_norm_round.sv
// Directed bench for div_sp_norm_round: values, latency, backpressure, reset.
module tb_div_sp_norm_round;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, o_ready, i_sign, i_sticky, o_valid, i_ready;
  logic [9:0]  i_exp;
  logic [26:0] i_mant;
  logic [1:0]  i_special;
  logic [31:0] o_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_sp_norm_round dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign(i_sign), .i_exp(i_exp), .i_mant(i_mant), .i_sticky(i_sticky),
    .i_special(i_special), .o_valid(o_valid), .i_ready(i_ready), .o_z(o_z)
  );

  // Drives one operand, returns o_z and accept-to-valid latency (999 = timeout).
  task automatic issue(input logic sg, input logic [9:0] ex, input logic [26:0] mt,
                       input logic st, input logic [1:0] sp,
                       output logic [31:0] z, output int lat);
    @(negedge clk);
    i_valid = 1'b1; i_sign = sg; i_exp = ex; i_mant = mt;
    i_sticky = st; i_special = sp;
    @(posedge clk);
    #1 i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!o_valid) lat = 999;
    z = o_z;
  endtask

  task automatic consume();
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1 i_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_valid = 1'b0; i_ready = 1'b0; i_sign = 1'b0; i_exp = '0;
    i_mant = '0; i_sticky = 1'b0; i_special = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
    checks++; if (o_z !== 32'h0) begin errors++; $display("FAIL reset_o_z got %h want 00000000", o_z); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_o_ready got %b want 1", o_ready); end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_normalize();
    logic [31:0] z; int lat;
    logic [9:0]  ex [3] = '{10'd0, 10'd1, 10'd26};
    logic [26:0] mt [3] = '{27'h4000000, 27'h2000000, 27'h0000001};
    int          lt [3] = '{3, 4, 29};
    for (int k = 0; k < 3; k++) begin
      issue(1'b0, ex[k], mt[k], 1'b0, 2'b00, z, lat);
      checks++; if (z !== 32'h3F800000) begin errors++; $display("FAIL norm%0d_z got %h want 3f800000", k, z); end
      checks++; if (lat != lt[k]) begin errors++; $display("FAIL norm%0d_latency got %0d want %0d", k, lat, lt[k]); end
      consume();
      checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL norm%0d_handoff got v=%b r=%b want v=0 r=1", k, o_valid, o_ready); end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] z; int lat;
    logic [26:0] mt [3] = '{27'h4000004, 27'h7FFFFFC, 27'h4000006};
    logic [31:0] ez [3] = '{32'h3F800000, 32'h40000000, 32'h3F800001};
    for (int k = 0; k < 3; k++) begin
      issue(1'b0, 10'd0, mt[k], 1'b0, 2'b00, z, lat);
      checks++; if (z !== ez[k]) begin errors++; $display("FAIL round%0d_z got %h want %h", k, z, ez[k]); end
      consume();
    end
    // sticky alone breaks a tie toward up
    issue(1'b0, 10'd0, 27'h4000004, 1'b1, 2'b00, z, lat);
    checks++; if (z !== 32'h3F800001) begin errors++; $display("FAIL round_sticky_z got %h want 3f800001", z); end
    consume();
  endtask

  task automatic test_range();
    logic [31:0] z; int lat;
    issue(1'b0, 10'd127, 27'h7FFFFFC, 1'b0, 2'b00, z, lat);
    checks++; if (z !== 32'h7F800000) begin errors++; $display("FAIL range_ovf_z got %h want 7f800000", z); end
    consume();
    issue(1'b1, -10'sd127, 27'h4000000, 1'b0, 2'b00, z, lat);
    checks++; if (z !== 32'h80000000) begin errors++; $display("FAIL range_flush_z got %h want 80000000", z); end
    consume();
    issue(1'b0, -10'sd126, 27'h4000000, 1'b0, 2'b00, z, lat);
    checks++; if (z !== 32'h00800000) begin errors++; $display("FAIL range_minnorm_z got %h want 00800000", z); end
    consume();
  endtask

  task automatic test_specials();
    logic [31:0] z; int lat;
    logic        sg [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0]  sp [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
    logic [31:0] ez [4] = '{32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h80000000};
    for (int k = 0; k < 4; k++) begin
      // last entry: normal code with a zero mantissa
      issue(sg[k], 10'd5, (k == 3) ? 27'h0 : 27'h4000000, 1'b0, sp[k], z, lat);
      checks++; if (z !== ez[k]) begin errors++; $display("FAIL special%0d_z got %h want %h", k, z, ez[k]); end
      checks++; if (lat != 1) begin errors++; $display("FAIL special%0d_latency got %0d want 1", k, lat); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] z; int lat;
    issue(1'b0, 10'd0, 27'h4000006, 1'b0, 2'b00, z, lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (o_valid !== 1'b1 || o_z !== 32'h3F800001 || o_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d got v=%b z=%h r=%b want v=1 z=3f800001 r=0", c, o_valid, o_z, o_ready);
      end
    end
    consume();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_z !== 32'h3F800001 || o_valid !== 1'b0) begin errors++; $display("FAIL retain got v=%b z=%h want v=0 z=3f800001", o_valid, o_z); end
  endtask

  task automatic test_reset_mid_norm();
    logic [31:0] z; int lat;
    @(negedge clk);
    i_valid = 1'b1; i_sign = 1'b0; i_exp = 10'd26; i_mant = 27'h0000001;
    i_sticky = 1'b0; i_special = 2'b00;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL midreset_o_ready got %b want 1", o_ready); end
    checks++; if (o_valid !== 1'b0 || o_z !== 32'h0) begin errors++; $display("FAIL midreset_out got v=%b z=%h want v=0 z=00000000", o_valid, o_z); end
    @(negedge clk) reset = 1'b0;
    issue(1'b1, 10'd2, 27'h4000000, 1'b0, 2'b00, z, lat);
    checks++; if (z !== 32'hC0800000) begin errors++; $display("FAIL postreset_z got %h want c0800000", z); end
    checks++; if (lat != 3) begin errors++; $display("FAIL postreset_latency got %0d want 3", lat); end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [31:0] z; int lat;
    issue(1'b0, 10'd1, 27'h6000000, 1'b0, 2'b00, z, lat);   // 1.5 * 2 = 3.0
    checks++; if (z !== 32'h40400000) begin errors++; $display("FAIL b2b0_z got %h want 40400000", z); end
    consume();
    issue(1'b1, -10'sd1, 27'h3000000, 1'b0, 2'b00, z, lat); // -0.75 * 0.5 = -0.375
    checks++; if (z !== 32'hBEC00000) begin errors++; $display("FAIL b2b1_z got %h want bec00000", z); end
    checks++; if (lat != 4) begin errors++; $display("FAIL b2b1_latency got %0d want 4", lat); end
    consume();
  endtask

  initial begin
    test_reset();
    test_normalize();
    test_rounding();
    test_range();
    test_specials();
    test_backpressure();
    test_reset_mid_norm();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sp_norm_round.md
Name: div_sp_norm_round

Overview:
Post-divide normalize/round/pack stage that sits directly downstream of the single-precision divider core.
- Accepts sign, unbiased exponent, a 27-bit raw quotient with guard/round bits, a sticky flag and a special-case code.
- Normalizes one bit per cycle, rounds to nearest-even and packs an IEEE-754 single.
- Valid/ready handshake on both sides; the output is held until consumed.

Parameters:
BIAS, 127, single-precision exponent bias
EXP_W, 10, width of signed unbiased input exponent
QNAN, 32'h7FC00000, canonical quiet-NaN result

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
i_valid  in  1  upstream result available
o_ready  out  1  stage can accept (high only in S_IDLE)
i_sign  in  1  result sign
i_exp  in  EXP_W  signed unbiased exponent; value = i_mant/2^26 * 2^i_exp
i_mant  in  27  bit26 = integer position, [25:3] fraction, [2] guard, [1:0] round/sticky
i_sticky  in  1  OR of remainder bits below i_mant
i_special  in  2  00 normal, 01 zero, 10 infinity, 11 NaN
o_valid  out  1  o_z holds a result
i_ready  in  1  downstream accepts o_z
o_z  out  32  packed single-precision result

Behaviour:
- Reset: one clock, asynchronous, active-high. Asserted → state S_IDLE, o_valid=0, o_z=0, o_ready=1, all internal registers 0. Takes effect immediately, including mid-normalize or while holding output; any in-flight result is discarded.
- Handshake: transfer in when i_valid & o_ready. Transfer out when o_valid & i_ready. o_ready=0 outside S_IDLE, so there is no input/output overlap.
- S_IDLE: on accept, latch all inputs.
  - i_special=01 → o_z={sign,31'b0}, go S_OUT.
  - i_special=10 → o_z={sign,8'hFF,23'b0}, go S_OUT.
  - i_special=11 → o_z=QNAN (sign ignored), go S_OUT.
  - i_special=00 with i_mant=0 → signed zero, go S_OUT.
  - Otherwise go S_NORM.
- S_NORM:
  - If m[26]=0: m<=m<<1, exp<=exp-1, stay.
  - Else go S_ROUND.
  - At most 26 shifts.
  - exp arithmetic is signed EXP_W+1 bits; no wrap is permitted.
- S_ROUND: combinational round+pack, registered into o_z, go S_OUT.
  - lsb=m[3], g=m[2], s=m[1]|m[0]|sticky; up = g & (s | lsb).
  - r = {1'b0, m[26:3]} + up. If r[24]: mantissa = r[24:1], exp+1.
  - be = exp + BIAS, computed after the carry adjust.
  - be >= 255 → {sign,8'hFF,0}.
  - be <= 0 → {sign,31'b0}; subnormals are flushed to zero.
  - Else {sign, be[7:0], mantissa[22:0]}.
- S_OUT: o_valid=1, o_z stable. When i_ready=1, o_valid drops next cycle and the state returns to S_IDLE.
- Latency, accept edge to o_valid high:
  - Special or zero: 1 cycle.
  - Normal with m[26]=1: 3 cycles.
  - Each leading zero adds 1 cycle.
- o_z is only defined when o_valid=1. It retains its last value after handoff until the next result.

Decomposition:
- Package div_sp_pkg:
  - BIAS, EXP_ALL_ONES=8'hFF, QNAN.
  - Special-code constants SPC_NORM/ZERO/INF/NAN.
  - State typedef {S_IDLE, S_NORM, S_ROUND, S_OUT}.
  - Shared by the divider and this stage.
- One combinational sub-module, div_sp_rne_pack: takes sign, exponent and normalized mantissa; produces the packed 32-bit word. Reusable for a future mul_sp.

Test Plan:
- Basic: i_exp=0, i_mant=27'h4000000, sticky=0, special=00 → o_z=32'h3F800000, o_valid 3 cycles after accept.
- Normalize: i_exp=1, i_mant=27'h2000000 → o_z=32'h3F800000, 4 cycles.
- Max normalize: i_exp=26, i_mant=27'h0000001 → o_z=32'h3F800000, 29 cycles.
- Rounding:
  - i_mant=27'h4000004, exp=0 (tie, lsb=0) → 32'h3F800000.
  - i_mant=27'h7FFFFFC, exp=0 (tie, lsb=1, carry) → 32'h40000000.
  - i_mant=27'h4000006 → 32'h3F800001.
- Range:
  - exp=127, i_mant=27'h7FFFFFC → 32'h7F800000 (rounding overflow).
  - exp=-127, sign=1, i_mant=27'h4000000 → 32'h80000000.
  - exp=-126 → 32'h00800000.
- Specials: special=11 → 32'h7FC00000; special=10 with sign=1 → 32'hFF800000; special=01 with sign=1 → 32'h80000000. Each 1 cycle after accept.
- Backpressure/reset:
  - Hold i_ready=0 for 5 cycles → o_z and o_valid stable, o_ready=0.
  - Assert reset mid-S_NORM (i_mant=27'h0000001) → o_valid=0, o_z=0, o_ready=1 before the next clock edge; a subsequent accept produces the correct result.
